// File: rtl/err_stats_collector.sv
// Multi-channel sum-of-squared-error collector with scaled, saturated per-channel readout.
// Optional feature: define ERR_COLLECTOR_MAXABS_EN to add per-channel max |ref - in| tracking (out_maxabs).
module err_stats_collector #(
  parameter  int DW      = 29,
  parameter  int NCH     = 4,
  parameter  int SEQ_LEN = 131072,
  parameter  int SHIFT   = 13,
  localparam int AW      = 2*(DW+1) + $clog2(SEQ_LEN) + 1,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH*DW-1:0] data_ref,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_chan,
  output logic [63:0]       out_data,
  output logic              out_sat,
  output logic              out_last
`ifdef ERR_COLLECTOR_MAXABS_EN
  ,
  output logic [DW:0]       out_maxabs
`endif
);

  localparam int NW = $clog2(SEQ_LEN + 1);
  localparam int SW = 2*(DW+1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  function automatic logic signed [DW:0] lane_diff(input logic [DW-1:0] r, input logic [DW-1:0] i);
    return $signed({r[DW-1], r}) - $signed({i[DW-1], i});
  endfunction

  function automatic logic [SW-1:0] square(input logic signed [DW:0] d);
    logic signed [SW-1:0] dx;
    dx = {{(DW+1){d[DW]}}, d};
    return dx * dx;
  endfunction

  function automatic logic [DW:0] absval(input logic signed [DW:0] d);
    return d[DW] ? -d : d;
  endfunction

  // Returns {sat, data}; the wide zero-extended copy keeps the shift legal for any AW.
  function automatic logic [64:0] scale_sat(input logic [AW-1:0] a);
    logic [AW+63:0] v;
    v = {64'd0, a} >> SHIFT;
    if (|v[AW+63:64]) return {1'b1, {64{1'b1}}};
    return {1'b0, v[63:0]};
  endfunction

  state_t          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic            accept, clr;

  logic            vld_p1, vld_p2;
  logic signed [DW:0] diff_p1 [NCH];
  logic [SW-1:0]   sq_p2  [NCH];
  logic [AW-1:0]   acc_q  [NCH];
  logic [64:0]     beat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      chan_q  <= chan_d;
    end
  end

  // The counter saturates at SEQ_LEN; the cycle after the last sample is still ACCUM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    chan_d  = chan_q;
    accept  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (cnt_q == NW'(SEQ_LEN)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else if (in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = OUTPUT;
          drain_d = 1'b0;
          chan_d  = '0;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (chan_q == CW'(NCH-1)) begin
            state_d = IDLE;
            chan_d  = '0;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: lane difference
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < NCH; k++) diff_p1[k] <= '0;
    end else begin
      vld_p1 <= accept;
      for (int k = 0; k < NCH; k++)
        if (accept) diff_p1[k] <= lane_diff(data_ref[k*DW +: DW], data_in[k*DW +: DW]);
    end
  end

  // Stage 2: square
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p2 <= 1'b0;
      for (int k = 0; k < NCH; k++) sq_p2[k] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int k = 0; k < NCH; k++)
        if (vld_p1) sq_p2[k] <= square(diff_p1[k]);
    end
  end

  // Stage 3: accumulate
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (clr)         acc_q[k] <= '0;
        else if (vld_p2) acc_q[k] <= acc_q[k] + {{(AW-SW){1'b0}}, sq_p2[k]};
      end
    end
  end

`ifdef ERR_COLLECTOR_MAXABS_EN
  logic [DW:0] abs_p2    [NCH];
  logic [DW:0] maxabs_q  [NCH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NCH; k++) begin
        abs_p2[k]   <= '0;
        maxabs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (vld_p1) abs_p2[k] <= absval(diff_p1[k]);
        if (clr)                                maxabs_q[k] <= '0;
        else if (vld_p2 && abs_p2[k] > maxabs_q[k]) maxabs_q[k] <= abs_p2[k];
      end
    end
  end

  assign out_maxabs = out_valid ? maxabs_q[chan_q] : '0;
`endif

  assign beat      = scale_sat(acc_q[chan_q]);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUTPUT);
  assign out_chan  = chan_q;
  assign out_data  = out_valid ? beat[63:0] : 64'd0;
  assign out_sat   = out_valid & beat[64];
  assign out_last  = out_valid && (chan_q == CW'(NCH-1));

endmodule
